// File: rtl/tap_controller_if.sv
// JTAG-side and data-register-side signals of the TAP controller, bundled as one port.
// The controller takes the slave view; a board-level driver or bench takes the master view.
interface tap_controller_if #(
  parameter int IR_Length = 4
);
  logic                 TMS;
  logic                 TDI;
  logic                 TDO;
  logic                 TDO_EN;
  logic                 tdr_tdo;
  logic                 tdr_select;
  logic                 Capture_DR;
  logic                 Shift_DR;
  logic                 Update_DR;
  logic [IR_Length-1:0] IR_OUT;
  logic [3:0]           tap_state;

  modport slave (
    input  TMS, TDI, tdr_tdo,
    output TDO, TDO_EN, tdr_select, Capture_DR, Shift_DR, Update_DR, IR_OUT, tap_state
  );

  modport master (
    output TMS, TDI, tdr_tdo,
    input  TDO, TDO_EN, tdr_select, Capture_DR, Shift_DR, Update_DR, IR_OUT, tap_state
  );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, bypass register,
// and strobes/select for one external user data register.
module tap_controller #(
  parameter int                   IR_Length     = 4,
  parameter logic [IR_Length-1:0] USER_OPCODE   = 4'b0010,
  parameter logic [IR_Length-1:0] BYPASS_OPCODE = {IR_Length{1'b1}}
) (
  input  logic              TCK,
  input  logic              TRST_N,
  tap_controller_if.slave   jtag
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } state_t;

  state_t               state;
  logic [IR_Length-1:0] ir_shift;
  logic [IR_Length-1:0] ir_out;
  logic                 bypass_q;
  logic                 sel_user;

  // State register and next-state table, advanced by TMS on every TCK rising edge.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state <= TLR;
    end else begin
      case (state)
        TLR:     state <= jtag.TMS ? TLR    : RTI;
        RTI:     state <= jtag.TMS ? SEL_DR : RTI;
        SEL_DR:  state <= jtag.TMS ? SEL_IR : CAP_DR;
        CAP_DR:  state <= jtag.TMS ? EX1_DR : SH_DR;
        SH_DR:   state <= jtag.TMS ? EX1_DR : SH_DR;
        EX1_DR:  state <= jtag.TMS ? UPD_DR : PAU_DR;
        PAU_DR:  state <= jtag.TMS ? EX2_DR : PAU_DR;
        EX2_DR:  state <= jtag.TMS ? UPD_DR : SH_DR;
        UPD_DR:  state <= jtag.TMS ? SEL_DR : RTI;
        SEL_IR:  state <= jtag.TMS ? TLR    : CAP_IR;
        CAP_IR:  state <= jtag.TMS ? EX1_IR : SH_IR;
        SH_IR:   state <= jtag.TMS ? EX1_IR : SH_IR;
        EX1_IR:  state <= jtag.TMS ? UPD_IR : PAU_IR;
        PAU_IR:  state <= jtag.TMS ? EX2_IR : PAU_IR;
        EX2_IR:  state <= jtag.TMS ? UPD_IR : SH_IR;
        UPD_IR:  state <= jtag.TMS ? SEL_DR : RTI;
        default: state <= TLR;
      endcase
    end
  end

  // Instruction path: capture pattern 0..01 makes the IR chain length visible on TDO.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_shift <= '0;
      ir_out   <= BYPASS_OPCODE;
    end else begin
      case (state)
        CAP_IR:  ir_shift <= IR_Length'(2'b01);
        SH_IR:   ir_shift <= {ir_shift[IR_Length-2:0], jtag.TDI};
        default: ir_shift <= ir_shift;
      endcase
      if (state == UPD_IR)
        ir_out <= ir_shift;
      else if (state == TLR)
        ir_out <= BYPASS_OPCODE;
    end
  end

  assign sel_user = (ir_out == USER_OPCODE);

  // Bypass is only clocked while the user register is not selected; pause states hold it.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      bypass_q <= 1'b0;
    end else if (!sel_user) begin
      if (state == CAP_DR)
        bypass_q <= 1'b0;
      else if (state == SH_DR)
        bypass_q <= jtag.TDI;
    end
  end

  always_comb begin
    jtag.TDO    = 1'b0;
    jtag.TDO_EN = 1'b0;
    if (state == SH_IR) begin
      jtag.TDO    = ir_shift[IR_Length-1];
      jtag.TDO_EN = 1'b1;
    end else if (state == SH_DR) begin
      jtag.TDO    = sel_user ? jtag.tdr_tdo : bypass_q;
      jtag.TDO_EN = 1'b1;
    end
  end

  assign jtag.Capture_DR = (state == CAP_DR);
  assign jtag.Shift_DR   = (state == SH_DR);
  assign jtag.Update_DR  = (state == UPD_DR);
  assign jtag.tdr_select = sel_user;
  assign jtag.IR_OUT     = ir_out;
  assign jtag.tap_state  = state;

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: reset, state walk, IR load, user DR, bypass, pause.
module tb_tap_controller;

  logic TCK;
  logic TRST_N;
  int   tests_run;
  int   tests_failed;

  tap_controller_if #(.IR_Length(4)) jtag();

  tap_controller #(
    .IR_Length(4),
    .USER_OPCODE(4'b0010),
    .BYPASS_OPCODE(4'b1111)
  ) dut (
    .TCK(TCK),
    .TRST_N(TRST_N),
    .jtag(jtag)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic drive(input logic tms, input logic tdi);
    jtag.TMS = tms;
    jtag.TDI = tdi;
    #1;
  endtask

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  task automatic go_tlr();
    drive(1'b1, 1'b0);
    repeat (5) tick();
  endtask

  // From RTI: scan an opcode MSB first, update, return to RTI.
  task automatic load_ir(input logic [3:0] op);
    drive(1'b1, 1'b0); tick();
    tick();
    drive(1'b0, 1'b0); tick();
    tick();
    for (int i = 3; i >= 0; i--) begin
      drive(i == 0, op[i]);
      tick();
    end
    drive(1'b1, 1'b0); tick();
    drive(1'b0, 1'b0); tick();
  endtask

  task automatic test_reset();
    TRST_N = 1'b0;
    jtag.TMS = 1'b0; jtag.TDI = 1'b1; jtag.tdr_tdo = 1'b1;
    repeat (2) @(posedge TCK);
    #2;
    tests_run++;
    if (jtag.tap_state !== 4'd0) begin tests_failed++; $display("FAIL rst_state: got %0d expected 0", jtag.tap_state); end
    tests_run++;
    if (jtag.IR_OUT !== 4'b1111) begin tests_failed++; $display("FAIL rst_ir_out: got %b expected 1111", jtag.IR_OUT); end
    tests_run++;
    if ({jtag.Capture_DR, jtag.Shift_DR, jtag.Update_DR, jtag.tdr_select} !== 4'b0000) begin
      tests_failed++; $display("FAIL rst_strobes: got %b expected 0000",
        {jtag.Capture_DR, jtag.Shift_DR, jtag.Update_DR, jtag.tdr_select});
    end
    tests_run++;
    if ({jtag.TDO, jtag.TDO_EN} !== 2'b00) begin tests_failed++; $display("FAIL rst_tdo: got %b expected 00", {jtag.TDO, jtag.TDO_EN}); end
    jtag.tdr_tdo = 1'b0;
  endtask

  task automatic test_reset_release();
    drive(1'b1, 1'b0);
    TRST_N = 1'b1;
    tick(); tick();
    tests_run++;
    if (jtag.tap_state !== 4'd0) begin tests_failed++; $display("FAIL rel_hold_tlr: got %0d expected 0", jtag.tap_state); end
    drive(1'b0, 1'b0);
    tick();
    tests_run++;
    if (jtag.tap_state !== 4'd1) begin tests_failed++; $display("FAIL rel_to_rti: got %0d expected 1", jtag.tap_state); end
  endtask

  task automatic test_all_states();
    int         plen [16];
    logic [6:0] pbits[16];
    plen  = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    // bit k of pbits is the TMS value on the k-th edge out of TLR
    pbits = '{7'b0000000, 7'b0000000, 7'b0000010, 7'b0000010,
              7'b0000010, 7'b0001010, 7'b0001010, 7'b0101010,
              7'b0011010, 7'b0000110, 7'b0000110, 7'b0000110,
              7'b0010110, 7'b0010110, 7'b1010110, 7'b0110110};
    for (int s = 0; s < 16; s++) begin
      go_tlr();
      for (int k = 0; k < plen[s]; k++) begin
        drive(pbits[s][k], 1'b0);
        tick();
      end
      tests_run++;
      if (jtag.tap_state !== 4'(s)) begin tests_failed++; $display("FAIL walk_reach_%0d: got %0d expected %0d", s, jtag.tap_state, s); end
      drive(1'b1, 1'b0);
      repeat (5) tick();
      tests_run++;
      if (jtag.tap_state !== 4'd0) begin tests_failed++; $display("FAIL walk_reset_from_%0d: got %0d expected 0", s, jtag.tap_state); end
    end
  endtask

  task automatic test_ir_load();
    logic tms_seq[5];
    logic tdi_seq[4];
    logic tdo_exp[4];
    tms_seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tdi_seq = '{1'b0, 1'b0, 1'b1, 1'b0};
    tdo_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
    go_tlr();
    for (int i = 0; i < 5; i++) begin
      drive(tms_seq[i], 1'b0);
      tick();
    end
    tests_run++;
    if (jtag.tap_state !== 4'd11) begin tests_failed++; $display("FAIL ir_at_shift: got %0d expected 11", jtag.tap_state); end
    for (int i = 0; i < 4; i++) begin
      drive(i == 3, tdi_seq[i]);
      tests_run++;
      if ({jtag.TDO_EN, jtag.TDO} !== {1'b1, tdo_exp[i]}) begin
        tests_failed++; $display("FAIL ir_tdo_bit%0d: got en/tdo %b expected %b", i, {jtag.TDO_EN, jtag.TDO}, {1'b1, tdo_exp[i]});
      end
      tick();
    end
    drive(1'b1, 1'b0); tick();
    tests_run++;
    if (jtag.IR_OUT !== 4'b1111) begin tests_failed++; $display("FAIL ir_hold_in_upd: got %b expected 1111", jtag.IR_OUT); end
    drive(1'b0, 1'b0); tick();
    tests_run++;
    if (jtag.IR_OUT !== 4'b0010) begin tests_failed++; $display("FAIL ir_out_user: got %b expected 0010", jtag.IR_OUT); end
    tests_run++;
    if (jtag.tdr_select !== 1'b1) begin tests_failed++; $display("FAIL ir_tdr_select: got %b expected 1", jtag.tdr_select); end
  endtask

  task automatic test_user_dr();
    logic pat[5];
    int   shift_cnt;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    shift_cnt = 0;
    drive(1'b1, 1'b0); tick();
    tests_run++;
    if (jtag.Capture_DR !== 1'b0) begin tests_failed++; $display("FAIL udr_cap_early: got %b expected 0", jtag.Capture_DR); end
    drive(1'b0, 1'b0); tick();
    tests_run++;
    if ({jtag.Capture_DR, jtag.Shift_DR, jtag.TDO_EN} !== 3'b100) begin
      tests_failed++; $display("FAIL udr_capture: got cap/sh/en %b expected 100", {jtag.Capture_DR, jtag.Shift_DR, jtag.TDO_EN});
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      jtag.tdr_tdo = pat[i];
      drive(i == 4, 1'b0);
      if (jtag.Shift_DR === 1'b1) shift_cnt++;
      tests_run++;
      if ({jtag.Capture_DR, jtag.TDO_EN, jtag.TDO} !== {1'b0, 1'b1, pat[i]}) begin
        tests_failed++; $display("FAIL udr_shift%0d: got cap/en/tdo %b expected %b", i, {jtag.Capture_DR, jtag.TDO_EN, jtag.TDO}, {1'b0, 1'b1, pat[i]});
      end
      tick();
    end
    if (jtag.Shift_DR === 1'b1) shift_cnt++;
    tests_run++;
    if (shift_cnt !== 5) begin tests_failed++; $display("FAIL udr_shift_count: got %0d expected 5", shift_cnt); end
    drive(1'b1, 1'b0); tick();
    tests_run++;
    if (jtag.Update_DR !== 1'b1) begin tests_failed++; $display("FAIL udr_update: got %b expected 1", jtag.Update_DR); end
    drive(1'b0, 1'b0); tick();
    tests_run++;
    if ({jtag.tap_state, jtag.Update_DR} !== {4'd1, 1'b0}) begin
      tests_failed++; $display("FAIL udr_update_end: got state/upd %0d/%b expected 1/0", jtag.tap_state, jtag.Update_DR);
    end
    jtag.tdr_tdo = 1'b0;
  endtask

  task automatic test_bypass();
    logic pat[4];
    logic exp[4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp = '{1'b0, 1'b1, 1'b0, 1'b1};
    load_ir(4'b0101);
    tests_run++;
    if ({jtag.IR_OUT, jtag.tdr_select} !== {4'b0101, 1'b0}) begin
      tests_failed++; $display("FAIL byp_ir: got ir/sel %b/%b expected 0101/0", jtag.IR_OUT, jtag.tdr_select);
    end
    jtag.tdr_tdo = 1'b1;
    drive(1'b1, 1'b0); tick();
    drive(1'b0, 1'b0); tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(i == 3, pat[i]);
      tests_run++;
      if (jtag.TDO !== exp[i]) begin tests_failed++; $display("FAIL byp_tdo%0d: got %b expected %b", i, jtag.TDO, exp[i]); end
      tick();
    end
    drive(1'b1, 1'b0); tick();
    drive(1'b0, 1'b0); tick();
    jtag.tdr_tdo = 1'b0;
  endtask

  task automatic test_pause();
    drive(1'b1, 1'b0); tick();
    drive(1'b0, 1'b0); tick();
    tick();
    drive(1'b0, 1'b1);
    tests_run++;
    if (jtag.TDO !== 1'b0) begin tests_failed++; $display("FAIL pau_first_bit: got %b expected 0", jtag.TDO); end
    tick();
    drive(1'b1, 1'b0);
    tests_run++;
    if (jtag.TDO !== 1'b1) begin tests_failed++; $display("FAIL pau_second_bit: got %b expected 1", jtag.TDO); end
    tick();
    drive(1'b0, 1'b1); tick();
    for (int j = 0; j < 3; j++) begin
      tests_run++;
      if ({jtag.tap_state, jtag.Shift_DR, jtag.TDO_EN, jtag.TDO} !== {4'd6, 3'b000}) begin
        tests_failed++; $display("FAIL pau_hold%0d: got state %0d sh/en/tdo %b expected 6 000", j, jtag.tap_state, {jtag.Shift_DR, jtag.TDO_EN, jtag.TDO});
      end
      drive(j == 2, 1'b1);
      tick();
    end
    drive(1'b0, 1'b1); tick();
    drive(1'b0, 1'b1);
    tests_run++;
    if ({jtag.Shift_DR, jtag.TDO} !== 2'b10) begin tests_failed++; $display("FAIL pau_resume0: got sh/tdo %b expected 10", {jtag.Shift_DR, jtag.TDO}); end
    tick();
    drive(1'b1, 1'b0);
    tests_run++;
    if (jtag.TDO !== 1'b1) begin tests_failed++; $display("FAIL pau_resume1: got %b expected 1", jtag.TDO); end
    tick();
    drive(1'b1, 1'b0); tick();
    drive(1'b0, 1'b0); tick();
  endtask

  task automatic test_reset_mid_shift();
    load_ir(4'b0010);
    drive(1'b1, 1'b0); tick();
    drive(1'b0, 1'b0); tick();
    tick();
    drive(1'b0, 1'b1);
    tests_run++;
    if (jtag.Shift_DR !== 1'b1) begin tests_failed++; $display("FAIL mid_in_shift: got %b expected 1", jtag.Shift_DR); end
    #2;
    TRST_N = 1'b0;
    #1;
    tests_run++;
    if ({jtag.tap_state, jtag.IR_OUT} !== {4'd0, 4'b1111}) begin
      tests_failed++; $display("FAIL mid_rst_now: got state/ir %0d/%b expected 0/1111", jtag.tap_state, jtag.IR_OUT);
    end
    tests_run++;
    if ({jtag.Shift_DR, jtag.Update_DR, jtag.tdr_select, jtag.TDO_EN} !== 4'b0000) begin
      tests_failed++; $display("FAIL mid_rst_outs: got %b expected 0000", {jtag.Shift_DR, jtag.Update_DR, jtag.tdr_select, jtag.TDO_EN});
    end
    drive(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if ({jtag.tap_state, jtag.Update_DR} !== {4'd0, 1'b0}) begin
        tests_failed++; $display("FAIL mid_rst_held%0d: got state/upd %0d/%b expected 0/0", i, jtag.tap_state, jtag.Update_DR);
      end
    end
    TRST_N = 1'b1;
    tick(); tick();
    tests_run++;
    if ({jtag.tap_state, jtag.Update_DR} !== {4'd0, 1'b0}) begin
      tests_failed++; $display("FAIL mid_rst_after: got state/upd %0d/%b expected 0/0", jtag.tap_state, jtag.Update_DR);
    end
  endtask

  task automatic test_tlr_bypass_load();
    drive(1'b0, 1'b0); tick();
    load_ir(4'b0010);
    tests_run++;
    if (jtag.IR_OUT !== 4'b0010) begin tests_failed++; $display("FAIL tlr_pre_ir: got %b expected 0010", jtag.IR_OUT); end
    drive(1'b1, 1'b0);
    tick(); tick(); tick();
    tests_run++;
    if ({jtag.tap_state, jtag.IR_OUT} !== {4'd0, 4'b0010}) begin
      tests_failed++; $display("FAIL tlr_entry: got state/ir %0d/%b expected 0/0010", jtag.tap_state, jtag.IR_OUT);
    end
    tick();
    tests_run++;
    if ({jtag.IR_OUT, jtag.tdr_select} !== {4'b1111, 1'b0}) begin
      tests_failed++; $display("FAIL tlr_bypass_load: got ir/sel %b/%b expected 1111/0", jtag.IR_OUT, jtag.tdr_select);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_reset_release();
    test_all_states();
    test_ir_load();
    test_user_dr();
    test_bypass();
    test_pause();
    test_reset_mid_shift();
    test_tlr_bypass_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
